// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   FSM sequencer for a multi-cycle RV32I core. Each instruction walks
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB), with a TRAP state for illegal
//   opcodes, ECALL/EBREAK and memory handshake timeouts.
//
// Parameters
//   MEM_TIMEOUT : wait cycles allowed for imem_ready/dmem_ready (1..255)
//   CUSTOM_EN   : 1 = custom-0 opcode runs as an I-type ALU op with custom_strobe
//   SYSTEM_EN   : 1 = SYSTEM opcode raises an environment trap, 0 = illegal
//
// Ports
//   clk, rst_n              : clock (rising edge), async active-low reset
//   op, op_lo               : instr[6:2] and instr[1:0], sampled in DECODE
//   imem_ready, dmem_ready  : memory handshake completions
//   trap_ack                : trap serviced, resume fetching
//   imem_req .. alu_op      : datapath strobes and mux selects
//   reg_write               : register file write (WB only)
//   custom_strobe           : custom-op execute pulse
//   trap, trap_cause        : trap pending and its cause
//   state_o                 : current state for debug
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CUSTOM_EN   = 0,
    parameter int SYSTEM_EN   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] op,
    input  logic [1:0] op_lo,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       trap_ack,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       custom_strobe,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [4:0] OP_LOAD    = 5'b00000;
    localparam logic [4:0] OP_STORE   = 5'b01000;
    localparam logic [4:0] OP_BRANCH  = 5'b11000;
    localparam logic [4:0] OP_JALR    = 5'b11001;
    localparam logic [4:0] OP_JAL     = 5'b11011;
    localparam logic [4:0] OP_ARITH_I = 5'b00100;
    localparam logic [4:0] OP_ARITH_R = 5'b01100;
    localparam logic [4:0] OP_AUIPC   = 5'b00101;
    localparam logic [4:0] OP_LUI     = 5'b01101;
    localparam logic [4:0] OP_SYSTEM  = 5'b11100;
    localparam logic [4:0] OP_CUSTOM0 = 5'b00010;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b00;
    localparam logic [1:0] CAUSE_ENV     = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    // The counter holds the number of cycles already waited, so the last
    // permitted wait cycle is the one where it equals MEM_TIMEOUT-1; a ready
    // in that cycle still wins over the timeout.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [4:0] op_r;
    logic [7:0] wait_cnt_r;
    logic [1:0] cause_r;
    logic [1:0] cause_nxt_s;

    logic       imem_req_s;
    logic       dmem_req_s;
    logic       ir_write_s;
    logic       pc_write_s;
    logic       pc_write_cond_s;
    logic [1:0] pc_src_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic [1:0] mem_to_reg_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic       reg_write_s;
    logic       custom_strobe_s;
    logic       trap_s;
    logic [1:0] trap_cause_s;

    // Opcode legality: listed opcodes, optional custom-0 and SYSTEM, and the
    // 32-bit encoding marker in instr[1:0].
    function automatic logic op_legal(input logic [4:0] opc, input logic [1:0] lo);
        logic known;
        case (opc)
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL,
            OP_ARITH_I, OP_ARITH_R, OP_AUIPC, OP_LUI: known = 1'b1;
            OP_CUSTOM0: known = (CUSTOM_EN != 0);
            OP_SYSTEM:  known = (SYSTEM_EN != 0);
            default:    known = 1'b0;
        endcase
        return known && (lo == 2'b11);
    endfunction

    // Next-state and trap-cause selection.
    always_comb begin
        state_nxt_s = state_r;
        cause_nxt_s = cause_r;
        case (state_r)
            ST_FETCH: begin
                if (imem_ready) begin
                    state_nxt_s = ST_DECODE;
                end else if (wait_cnt_r == TIMEOUT_LAST) begin
                    state_nxt_s = ST_TRAP;
                    cause_nxt_s = CAUSE_IMEM;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (!op_legal(op, op_lo)) begin
                    state_nxt_s = ST_TRAP;
                    cause_nxt_s = CAUSE_ILLEGAL;
                end else if (op == OP_SYSTEM) begin
                    state_nxt_s = ST_TRAP;
                    cause_nxt_s = CAUSE_ENV;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_r)
                    OP_LOAD, OP_STORE: state_nxt_s = ST_MEM;
                    OP_BRANCH:         state_nxt_s = ST_FETCH;
                    default:           state_nxt_s = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_nxt_s = (op_r == OP_LOAD) ? ST_WB : ST_FETCH;
                end else if (wait_cnt_r == TIMEOUT_LAST) begin
                    state_nxt_s = ST_TRAP;
                    cause_nxt_s = CAUSE_DMEM;
                end else begin
                    state_nxt_s = ST_MEM;
                end
            end
            ST_WB: begin
                state_nxt_s = ST_FETCH;
            end
            ST_TRAP: begin
                if (trap_ack) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_TRAP;
                end
            end
            default: begin
                state_nxt_s = ST_FETCH;
            end
        endcase
    end

    // State, latched opcode, trap cause and handshake wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FETCH;
            op_r       <= 5'd0;
            wait_cnt_r <= 8'd0;
            cause_r    <= 2'b00;
        end else begin
            state_r <= state_nxt_s;
            cause_r <= cause_nxt_s;
            if (state_r == ST_DECODE) begin
                op_r <= op;
            end else begin
                op_r <= op_r;
            end
            // Any state change (which includes every ready) restarts the count.
            if (state_nxt_s != state_r) begin
                wait_cnt_r <= 8'd0;
            end else if ((state_r == ST_FETCH) || (state_r == ST_MEM)) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= 8'd0;
            end
        end
    end

    // Moore output decode from state and latched opcode; forced low in reset
    // so an asynchronous reset silences every strobe immediately.
    always_comb begin
        imem_req_s      = 1'b0;
        dmem_req_s      = 1'b0;
        ir_write_s      = 1'b0;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        pc_src_s        = 2'b00;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        mem_to_reg_s    = 2'b00;
        alu_src_a_s     = 2'b00;
        alu_src_b_s     = 2'b00;
        alu_op_s        = 2'b00;
        reg_write_s     = 1'b0;
        custom_strobe_s = 1'b0;
        trap_s          = 1'b0;
        trap_cause_s    = 2'b00;
        if (rst_n) begin
            case (state_r)
                ST_FETCH: begin
                    imem_req_s = 1'b1;
                    // PC <= PC + 4 computed on the ALU as the word arrives.
                    if (imem_ready) begin
                        ir_write_s  = 1'b1;
                        pc_write_s  = 1'b1;
                        pc_src_s    = 2'b00;
                        alu_src_a_s = 2'b01;
                        alu_src_b_s = 2'b10;
                    end else begin
                        ir_write_s = 1'b0;
                    end
                end
                ST_DECODE: begin
                    // Branch target precompute: pc + imm.
                    alu_src_a_s = 2'b01;
                    alu_src_b_s = 2'b01;
                    alu_op_s    = 2'b00;
                end
                ST_EXEC: begin
                    case (op_r)
                        OP_LOAD, OP_STORE: begin
                            alu_src_b_s = 2'b01;
                            alu_op_s    = 2'b00;
                        end
                        OP_ARITH_R: begin
                            alu_op_s = 2'b10;
                        end
                        OP_ARITH_I, OP_CUSTOM0: begin
                            alu_src_b_s     = 2'b01;
                            alu_op_s        = 2'b11;
                            custom_strobe_s = (op_r == OP_CUSTOM0);
                        end
                        OP_BRANCH: begin
                            alu_op_s        = 2'b01;
                            pc_write_cond_s = 1'b1;
                            pc_src_s        = 2'b01;
                        end
                        OP_JAL: begin
                            pc_write_s = 1'b1;
                            pc_src_s   = 2'b01;
                        end
                        OP_JALR: begin
                            alu_src_b_s = 2'b01;
                            pc_write_s  = 1'b1;
                            pc_src_s    = 2'b10;
                        end
                        OP_LUI: begin
                            alu_src_a_s = 2'b10;
                            alu_src_b_s = 2'b01;
                        end
                        OP_AUIPC: begin
                            alu_src_a_s = 2'b01;
                            alu_src_b_s = 2'b01;
                        end
                        default: begin
                            alu_op_s = 2'b00;
                        end
                    endcase
                end
                ST_MEM: begin
                    dmem_req_s  = 1'b1;
                    mem_read_s  = (op_r == OP_LOAD);
                    mem_write_s = (op_r == OP_STORE);
                end
                ST_WB: begin
                    reg_write_s = 1'b1;
                    case (op_r)
                        OP_LOAD:         mem_to_reg_s = 2'b01;
                        OP_JAL, OP_JALR: mem_to_reg_s = 2'b10;
                        default:         mem_to_reg_s = 2'b00;
                    endcase
                end
                ST_TRAP: begin
                    trap_s       = 1'b1;
                    trap_cause_s = cause_r;
                end
                default: begin
                    trap_s = 1'b0;
                end
            endcase
        end else begin
            // Held in reset: every output keeps its zero default.
            trap_s = 1'b0;
        end
    end

    assign imem_req      = imem_req_s;
    assign dmem_req      = dmem_req_s;
    assign ir_write      = ir_write_s;
    assign pc_write      = pc_write_s;
    assign pc_write_cond = pc_write_cond_s;
    assign pc_src        = pc_src_s;
    assign mem_read      = mem_read_s;
    assign mem_write     = mem_write_s;
    assign mem_to_reg    = mem_to_reg_s;
    assign alu_src_a     = alu_src_a_s;
    assign alu_src_b     = alu_src_b_s;
    assign alu_op        = alu_op_s;
    assign reg_write     = reg_write_s;
    assign custom_strobe = custom_strobe_s;
    assign trap          = trap_s;
    assign trap_cause    = trap_cause_s;
    assign state_o       = state_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Two instances share the inputs:
// dut uses the default parameters, dut_c has CUSTOM_EN=1 and SYSTEM_EN=0.
// Every cycle the state and a packed control word are compared with
// hand-derived expectations.
module tb_multicycle_control_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] op;
    logic [1:0] op_lo;
    logic       imem_ready;
    logic       dmem_ready;
    logic       trap_ack;

    logic       imem_req, dmem_req, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src, mem_to_reg, alu_src_a, alu_src_b, alu_op, trap_cause;
    logic       mem_read, mem_write, reg_write, custom_strobe, trap;
    logic [2:0] state_o;

    logic       c_imem_req, c_dmem_req, c_ir_write, c_pc_write, c_pc_write_cond;
    logic [1:0] c_pc_src, c_mem_to_reg, c_alu_src_a, c_alu_src_b, c_alu_op, c_trap_cause;
    logic       c_mem_read, c_mem_write, c_reg_write, c_custom_strobe, c_trap;
    logic [2:0] c_state_o;

    int   n_tests;
    int   n_fail;
    logic use_c;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    // Control word layout (MSB first):
    // imem_req dmem_req ir_write pc_write pc_write_cond pc_src[2] mem_read
    // mem_write mem_to_reg[2] alu_src_a[2] alu_src_b[2] alu_op[2] reg_write
    // custom_strobe trap trap_cause[2]
    localparam logic [21:0] F_IMREQ = 22'd1 << 21;
    localparam logic [21:0] F_DMREQ = 22'd1 << 20;
    localparam logic [21:0] F_IRW   = 22'd1 << 19;
    localparam logic [21:0] F_PCW   = 22'd1 << 18;
    localparam logic [21:0] F_PCWC  = 22'd1 << 17;
    localparam logic [21:0] F_SRC1  = 22'd1 << 15;
    localparam logic [21:0] F_MR    = 22'd1 << 14;
    localparam logic [21:0] F_MW    = 22'd1 << 13;
    localparam logic [21:0] F_M2R1  = 22'd1 << 11;
    localparam logic [21:0] F_M2R2  = 22'd2 << 11;
    localparam logic [21:0] F_APC   = 22'd1 << 9;
    localparam logic [21:0] F_BIMM  = 22'd1 << 7;
    localparam logic [21:0] F_B4    = 22'd2 << 7;
    localparam logic [21:0] F_AOPBR = 22'd1 << 5;
    localparam logic [21:0] F_AOPR  = 22'd2 << 5;
    localparam logic [21:0] F_AOPI  = 22'd3 << 5;
    localparam logic [21:0] F_RW    = 22'd1 << 4;
    localparam logic [21:0] F_CS    = 22'd1 << 3;
    localparam logic [21:0] F_TRAP  = 22'd1 << 2;

    localparam logic [21:0] C_FW    = F_IMREQ;
    localparam logic [21:0] C_FR    = F_IMREQ | F_IRW | F_PCW | F_APC | F_B4;
    localparam logic [21:0] C_DEC   = F_APC | F_BIMM;
    localparam logic [21:0] C_ER    = F_AOPR;
    localparam logic [21:0] C_ELS   = F_BIMM;
    localparam logic [21:0] C_ECUS  = F_BIMM | F_AOPI | F_CS;
    localparam logic [21:0] C_EBR   = F_AOPBR | F_PCWC | F_SRC1;
    localparam logic [21:0] C_EJAL  = F_PCW | F_SRC1;
    localparam logic [21:0] C_MLD   = F_DMREQ | F_MR;
    localparam logic [21:0] C_MST   = F_DMREQ | F_MW;
    localparam logic [21:0] C_WBR   = F_RW;
    localparam logic [21:0] C_WBL   = F_RW | F_M2R1;
    localparam logic [21:0] C_WBJ   = F_RW | F_M2R2;
    localparam logic [21:0] C_T_ILL = F_TRAP;
    localparam logic [21:0] C_T_ENV = F_TRAP | 22'd1;
    localparam logic [21:0] C_T_IM  = F_TRAP | 22'd2;
    localparam logic [21:0] C_T_DM  = F_TRAP | 22'd3;

    logic [21:0] ctl, c_ctl;
    assign ctl = {imem_req, dmem_req, ir_write, pc_write, pc_write_cond, pc_src,
                  mem_read, mem_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                  reg_write, custom_strobe, trap, trap_cause};
    assign c_ctl = {c_imem_req, c_dmem_req, c_ir_write, c_pc_write, c_pc_write_cond, c_pc_src,
                    c_mem_read, c_mem_write, c_mem_to_reg, c_alu_src_a, c_alu_src_b, c_alu_op,
                    c_reg_write, c_custom_strobe, c_trap, c_trap_cause};

    multicycle_control_unit #(.MEM_TIMEOUT(15), .CUSTOM_EN(0), .SYSTEM_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .op_lo(op_lo),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .trap_ack(trap_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .custom_strobe(custom_strobe), .trap(trap),
        .trap_cause(trap_cause), .state_o(state_o)
    );

    multicycle_control_unit #(.MEM_TIMEOUT(15), .CUSTOM_EN(1), .SYSTEM_EN(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .op(op), .op_lo(op_lo),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .trap_ack(trap_ack),
        .imem_req(c_imem_req), .dmem_req(c_dmem_req), .ir_write(c_ir_write),
        .pc_write(c_pc_write), .pc_write_cond(c_pc_write_cond), .pc_src(c_pc_src),
        .mem_read(c_mem_read), .mem_write(c_mem_write), .mem_to_reg(c_mem_to_reg),
        .alu_src_a(c_alu_src_a), .alu_src_b(c_alu_src_b), .alu_op(c_alu_op),
        .reg_write(c_reg_write), .custom_strobe(c_custom_strobe), .trap(c_trap),
        .trap_cause(c_trap_cause), .state_o(c_state_o)
    );

    // Clock: 10-time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_now(input string tag, input logic [2:0] est, input logic [21:0] ectl);
        logic [2:0]  obs_st;
        logic [21:0] obs_ctl;
        obs_st  = use_c ? c_state_o : state_o;
        obs_ctl = use_c ? c_ctl : ctl;
        n_tests++;
        assert (obs_st === est) else begin
            n_fail++;
            $error("FAIL %s state: got %0d expected %0d", tag, obs_st, est);
        end
        n_tests++;
        assert (obs_ctl === ectl) else begin
            n_fail++;
            $error("FAIL %s ctl: got %h expected %h", tag, obs_ctl, ectl);
        end
    endtask

    // Drive this cycle's handshake inputs, check, then advance one clock.
    task automatic step(input logic imr, input logic dmr, input logic ack,
                        input logic [2:0] est, input logic [21:0] ectl, input string tag);
        imem_ready = imr;
        dmem_ready = dmr;
        trap_ack   = ack;
        #1;
        chk_now(tag, est, ectl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        use_c      = 1'b0;
        rst_n      = 1'b0;
        op         = 5'b00000;
        op_lo      = 2'b11;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        trap_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Outputs silent in reset even with ready asserted.
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #1;
        chk_now("reset_quiet", S_FETCH, 22'd0);
        rst_n = 1'b1;

        // ARITH_R, zero wait: 4 cycles.
        op = 5'b01100;
        step(1'b1, 1'b1, 1'b0, S_FETCH,  C_FR,  "r_fetch");
        step(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC, "r_decode");
        step(1'b1, 1'b1, 1'b0, S_EXEC,   C_ER,  "r_exec");
        step(1'b1, 1'b1, 1'b0, S_WB,     C_WBR, "r_wb");

        // LOAD with dmem_ready 3 cycles late; op changed after DECODE is ignored.
        op = 5'b00000;
        step(1'b1, 1'b1, 1'b0, S_FETCH,  C_FR,  "ld_fetch");
        step(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC, "ld_decode");
        op = 5'b01000;
        step(1'b1, 1'b1, 1'b0, S_EXEC,   C_ELS, "ld_exec");
        step(1'b1, 1'b0, 1'b0, S_MEM,    C_MLD, "ld_mem0");
        step(1'b1, 1'b0, 1'b0, S_MEM,    C_MLD, "ld_mem1");
        step(1'b1, 1'b0, 1'b0, S_MEM,    C_MLD, "ld_mem2");
        step(1'b1, 1'b1, 1'b0, S_MEM,    C_MLD, "ld_mem3");
        step(1'b1, 1'b1, 1'b0, S_WB,     C_WBL, "ld_wb");

        // BRANCH: 3 cycles.
        op = 5'b11000;
        step(1'b1, 1'b1, 1'b0, S_FETCH,  C_FR,  "br_fetch");
        step(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC, "br_decode");
        step(1'b1, 1'b1, 1'b0, S_EXEC,   C_EBR, "br_exec");

        // JAL: writeback selects pc+4.
        op = 5'b11011;
        step(1'b1, 1'b1, 1'b0, S_FETCH,  C_FR,   "jal_fetch");
        step(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC,  "jal_decode");
        step(1'b1, 1'b1, 1'b0, S_EXEC,   C_EJAL, "jal_exec");
        step(1'b1, 1'b1, 1'b0, S_WB,     C_WBJ,  "jal_wb");

        // Fetch timeout; dmem_ready and trap_ack in FETCH must be ignored.
        op = 5'b01100;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, 1'b1, S_FETCH, C_FW, "imto_wait");
        end
        step(1'b0, 1'b0, 1'b0, S_TRAP,  C_T_IM, "imto_trap");
        step(1'b0, 1'b0, 1'b1, S_TRAP,  C_T_IM, "imto_ack");
        step(1'b0, 1'b0, 1'b0, S_FETCH, C_FW,   "imto_resume");

        // Ready in the last permitted wait cycle (15th) still succeeds.
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 1'b0, 1'b0, S_FETCH, C_FW, "edge_wait");
        end
        step(1'b1, 1'b0, 1'b0, S_FETCH,  C_FR,  "edge_ready");
        step(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC, "edge_decode");
        step(1'b1, 1'b1, 1'b0, S_EXEC,   C_ER,  "edge_exec");
        step(1'b1, 1'b1, 1'b0, S_WB,     C_WBR, "edge_wb");

        // CUSTOM0 illegal with CUSTOM_EN=0.
        op = 5'b00010;
        step(1'b1, 1'b1, 1'b0, S_FETCH,  C_FR,    "cus0_fetch");
        step(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC,   "cus0_decode");
        step(1'b1, 1'b1, 1'b0, S_TRAP,   C_T_ILL, "cus0_trap");
        step(1'b1, 1'b1, 1'b1, S_TRAP,   C_T_ILL, "cus0_ack");

        // SYSTEM -> environment trap.
        op = 5'b11100;
        step(1'b1, 1'b1, 1'b0, S_FETCH,  C_FR,    "sys_fetch");
        step(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC,   "sys_decode");
        step(1'b1, 1'b1, 1'b1, S_TRAP,   C_T_ENV, "sys_trap");

        // Bad low opcode bits -> illegal.
        op    = 5'b01100;
        op_lo = 2'b01;
        step(1'b1, 1'b1, 1'b0, S_FETCH,  C_FR,    "lo_fetch");
        step(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC,   "lo_decode");
        step(1'b1, 1'b1, 1'b1, S_TRAP,   C_T_ILL, "lo_trap");
        op_lo = 2'b11;

        // STORE with data timeout; imem_ready in MEM is ignored.
        op = 5'b01000;
        step(1'b1, 1'b1, 1'b0, S_FETCH,  C_FR,  "stto_fetch");
        step(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC, "stto_decode");
        step(1'b1, 1'b1, 1'b0, S_EXEC,   C_ELS, "stto_exec");
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 1'b0, S_MEM, C_MST, "stto_wait");
        end
        step(1'b1, 1'b0, 1'b1, S_TRAP, C_T_DM, "stto_trap");

        // STORE aborted by reset during MEM.
        step(1'b1, 1'b1, 1'b0, S_FETCH,  C_FR,  "st_fetch");
        step(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC, "st_decode");
        step(1'b1, 1'b1, 1'b0, S_EXEC,   C_ELS, "st_exec");
        step(1'b1, 1'b0, 1'b0, S_MEM,    C_MST, "st_mem");
        rst_n = 1'b0;
        #1;
        chk_now("st_abort", S_FETCH, 22'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, S_FETCH, C_FW, "st_post_reset");

        // CUSTOM_EN=1 / SYSTEM_EN=0 instance.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        use_c = 1'b1;
        op    = 5'b00010;
        step(1'b1, 1'b1, 1'b0, S_FETCH,  C_FR,   "cus1_fetch");
        step(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC,  "cus1_decode");
        op = 5'b11100;
        step(1'b1, 1'b1, 1'b0, S_EXEC,   C_ECUS, "cus1_exec");
        step(1'b1, 1'b1, 1'b0, S_WB,     C_WBR,  "cus1_wb");
        step(1'b1, 1'b1, 1'b0, S_FETCH,  C_FR,    "nosys_fetch");
        step(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC,   "nosys_decode");
        step(1'b1, 1'b1, 1'b1, S_TRAP,   C_T_ILL, "nosys_trap");
        step(1'b0, 1'b0, 1'b0, S_FETCH,  C_FW,    "nosys_resume");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised, FSM-based control unit for the multi-cycle RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and latches the opcode at decode.
- Drives the datapath strobes, ALU operand selects and alu_op.
- Handles instruction- and data-memory ready handshakes with timeout; traps on illegal opcodes, ECALL/EBREAK and bus timeouts.

Parameters:
- MEM_TIMEOUT, 15, maximum wait cycles for imem_ready/dmem_ready before a timeout trap (1..255).
- CUSTOM_EN, 0, 1 = the custom-0 opcode executes as an I-type ALU op with custom_strobe; 0 = illegal.
- SYSTEM_EN, 1, 1 = the SYSTEM opcode raises an environment trap; 0 = illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  5  instr[6:2], sampled in DECODE.
- op_lo  in  2  instr[1:0]; any value other than 2'b11 is illegal.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access complete this cycle.
- trap_ack  in  1  trap serviced; resume fetch.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC update.
- pc_write_cond  out  1  PC update if branch taken.
- pc_src  out  2  00 pc+4, 01 branch/JAL target, 10 JALR target (ALU & ~1).
- mem_read  out  1  data read.
- mem_write  out  1  data write.
- mem_to_reg  out  2  00 ALU, 01 memory, 10 pc+4.
- alu_src_a  out  2  00 rs1, 01 pc, 10 zero.
- alu_src_b  out  2  00 rs2, 01 imm, 10 const 4.
- alu_op  out  2  00 add, 01 branch compare, 10 R funct, 11 I funct.
- reg_write  out  1  register file write.
- custom_strobe  out  1  custom-op execute pulse.
- trap  out  1  trap pending.
- trap_cause  out  2  00 illegal, 01 environment, 10 imem timeout, 11 dmem timeout.
- state_o  out  3  current state, for debug.

Behaviour:
- Opcodes (op): LOAD 00000, STORE 01000, BRANCH 11000, JALR 11001, JAL 11011, ARITH_I 00100, ARITH_R 01100, AUIPC 00101, LUI 01101, SYSTEM 11100, CUSTOM0 00010.
- Outputs are Moore: decoded from the state register and the latched opcode. All outputs are 0 whenever no state asserts them.
- Reset: state = FETCH, latched op = 0, wait counter = 0, trap = 0, trap_cause = 0. All outputs are 0 while rst_n is low. Asynchronous reset mid-instruction aborts it with no further strobes.
- FETCH:
  - imem_req = 1.
  - On imem_ready: ir_write = 1, pc_write = 1, pc_src = 00, alu_src_a = 01, alu_src_b = 10; next state DECODE.
  - Otherwise the wait counter increments. When the counter reaches MEM_TIMEOUT without imem_ready: TRAP, cause 10.
- DECODE:
  - Latch op.
  - alu_src_a = 01, alu_src_b = 01, alu_op = 00 (branch target precompute).
  - Illegal if op_lo != 11, op is unlisted, op = CUSTOM0 with CUSTOM_EN = 0, or op = SYSTEM with SYSTEM_EN = 0 → TRAP, cause 00.
  - op = SYSTEM with SYSTEM_EN = 1 → TRAP, cause 01.
  - Otherwise → EXEC.
- EXEC:
  - LOAD/STORE: alu_src_b = 01, alu_op = 00 → MEM.
  - ARITH_R: alu_op = 10 → WB.
  - ARITH_I/CUSTOM0: alu_src_b = 01, alu_op = 11, custom_strobe = 1 for CUSTOM0 only → WB.
  - BRANCH: alu_op = 01, pc_write_cond = 1, pc_src = 01 → FETCH.
  - JAL: pc_write = 1, pc_src = 01 → WB.
  - JALR: alu_src_b = 01, pc_write = 1, pc_src = 10 → WB.
  - LUI: alu_src_a = 10, alu_src_b = 01 → WB.
  - AUIPC: alu_src_a = 01, alu_src_b = 01 → WB.
- MEM:
  - dmem_req = 1; mem_read = 1 for LOAD, mem_write = 1 for STORE. Signals are held stable until dmem_ready.
  - On dmem_ready: LOAD → WB, STORE → FETCH.
  - Timeout at MEM_TIMEOUT cycles → TRAP, cause 11.
- WB:
  - reg_write = 1, for exactly one cycle → FETCH.
  - mem_to_reg = 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
- TRAP:
  - trap = 1 and trap_cause held; no strobes asserted.
  - trap_ack → FETCH next cycle with trap cleared.
  - trap_ack outside TRAP is ignored.
- Wait counter: 8 bits; clears on every state change and on ready.
- Handshake edge cases:
  - ready arriving in the same cycle the counter hits MEM_TIMEOUT counts as success.
  - ready is ignored when no request is active.
- Zero-wait cycle counts:
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.

Test Plan:
- Reset, then op = 01100, op_lo = 11, ready always 1 → states FETCH, DECODE, EXEC, WB; reg_write high only in cycle 4; alu_op = 10 in EXEC.
- LOAD with dmem_ready delayed 3 cycles → dmem_req and mem_read held for 4 cycles; WB with mem_to_reg = 01; 8 cycles total.
- imem_ready never asserted, MEM_TIMEOUT = 15 → TRAP after 15 FETCH cycles, trap_cause = 10; trap_ack → FETCH with trap = 0.
- op = 00010 with CUSTOM_EN = 0 → TRAP, cause 00. Rerun with CUSTOM_EN = 1 → one-cycle custom_strobe in EXEC, then WB.
- op = 11100 → TRAP, cause 01. op_lo = 01 with any op → TRAP, cause 00.
- rst_n pulsed low during MEM of a STORE → mem_write and dmem_req drop immediately; after release, state is FETCH with imem_req = 1.
